// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle controller: opcodes, states,
// PCSrc/ALUOp codes and instruction classes.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_REG = 2'b11;

    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_FN  = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_R   = 4'd0,
        C_I   = 4'd1,
        C_LW  = 4'd2,
        C_SW  = 4'd3,
        C_BEQ = 4'd4,
        C_BNE = 4'd5,
        C_J   = 4'd6,
        C_JAL = 4'd7,
        C_JR  = 4'd8,
        C_ILL = 4'd9
    } op_class_e;

endpackage

// File: rtl/op_class_decode.sv
// Maps opcode/funct to one instruction class; anything unknown is C_ILL.
module op_class_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] cls
);

    always_comb begin
        cls = C_ILL;
        case (opcode)
            OP_RTYPE: cls = (funct == FN_JR) ? C_JR : C_R;
            OP_LW:    cls = C_LW;
            OP_SW:    cls = C_SW;
            OP_BEQ:   cls = C_BEQ;
            OP_BNE:   cls = C_BNE;
            OP_J:     cls = C_J;
            OP_JAL:   cls = C_JAL;
            default: begin
                if (opcode[5:3] == 3'b001) cls = C_I;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath sharing one
// memory port for fetch and data; stalls on mem_ack with a timeout.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic [5:0]  Function_opcode,
    input  logic        Zero,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        IorD,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        MemtoReg,
    output logic        RegDST,
    output logic        ALUSrc,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ALUOp,
    output logic [2:0]  state,
    output logic [31:0] retired,
    output logic        fault
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1) + 1;

    state_e       state_q, state_d;
    logic [TW-1:0] wait_q, wait_d;
    logic         fault_q, fault_d;
    logic [31:0]  retired_q, retired_d;
    logic [3:0]   cls_raw;
    op_class_e    cls;
    logic         timeout;

    op_class_decode u_dec (
        .opcode (Opcode),
        .funct  (Function_opcode),
        .cls    (cls_raw)
    );

    assign cls     = op_class_e'(cls_raw);
    assign timeout = (wait_q >= TW'(MEM_TIMEOUT));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        fault_d   = fault_q;
        retired_d = retired_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (cls)
                    C_R, C_I:   state_d = S_WB;
                    C_LW, C_SW: state_d = S_MEM;
                    C_ILL: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                    default:    state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = (cls == C_SW) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        // Only completed instructions re-enter FETCH from these states
        if (state_d == S_FETCH &&
            (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
            retired_d = retired_q + 32'd1;
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        RegDST   = 1'b0;
        ALUSrc   = 1'b0;
        PCSrc    = PCSRC_SEQ;
        ALUOp    = ALUOP_MEM;
        // Everything is held off while reset is asserted
        if (reset) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        IRWrite = 1'b1;
                        PCWrite = 1'b1;
                        PCSrc   = PCSRC_SEQ;
                    end
                end
                S_EXEC: begin
                    unique case (cls)
                        C_R: ALUOp = ALUOP_FN;
                        C_I: begin
                            ALUOp  = ALUOP_FN;
                            ALUSrc = 1'b1;
                        end
                        C_LW, C_SW: ALUSrc = 1'b1;
                        C_BEQ: begin
                            ALUOp   = ALUOP_BR;
                            PCSrc   = PCSRC_BR;
                            PCWrite = Zero;
                        end
                        C_BNE: begin
                            ALUOp   = ALUOP_BR;
                            PCSrc   = PCSRC_BR;
                            PCWrite = ~Zero;
                        end
                        C_J: begin
                            PCWrite = 1'b1;
                            PCSrc   = PCSRC_JMP;
                        end
                        C_JAL: begin
                            PCWrite  = 1'b1;
                            PCSrc    = PCSRC_JMP;
                            RegWrite = 1'b1;
                        end
                        C_JR: begin
                            PCWrite = 1'b1;
                            PCSrc   = PCSRC_REG;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                    mem_we  = (cls == C_SW);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls == C_LW);
                    RegDST   = (cls == C_R);
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign fault   = fault_q;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, meaning the max cycles to wait for mem_ack before raising a fault.
REQ-002 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-low reset; it is sampled only on the rising edge of clock.
REQ-004 SHALL have port Opcode, input, 6, instruction[31:26] from the instruction register.
REQ-005 SHALL have port Function_opcode, input, 6, instruction[5:0] from the instruction register.
REQ-006 SHALL have port Zero, input, 1, ALU zero flag, valid in EXEC.
REQ-007 SHALL have port mem_ack, input, 1, completion of the current shared-memory access.
REQ-008 SHALL have port mem_req, output, 1, shared memory port request.
REQ-009 SHALL have port mem_we, output, 1, write qualifier for mem_req.
REQ-010 SHALL have port IorD, output, 1: 0 = PC address, 1 = ALU address.
REQ-011 SHALL have ports IRWrite, PCWrite, RegWrite, MemtoReg, RegDST, ALUSrc, output, 1 each, datapath enables.
REQ-012 SHALL have port PCSrc, output, 2: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = register (jr).
REQ-013 SHALL have port ALUOp, output, 2: 00 = lw/sw, 01 = beq/bne, 10 = R-type/I-format.
REQ-014 SHALL have port state, output, 3, current FSM state for debug.
REQ-015 SHALL have port retired, output, 32, count of completed instructions.
REQ-016 SHALL have port fault, output, 1, sticky error: illegal opcode or memory timeout.

Function
REQ-017 SHALL implement a Moore FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; outputs decode from the registered state, with only PCWrite qualified by Zero.
REQ-018 In FETCH it SHALL assert mem_req with IorD=0 and mem_we=0; on mem_ack it SHALL assert IRWrite and PCWrite with PCSrc=00, then go to DECODE.
REQ-019 mem_req SHALL remain high until mem_ack is sampled; an ack in the same cycle as the request SHALL complete the access.
REQ-020 DECODE SHALL always go to EXEC on the next cycle.
REQ-021 EXEC SHALL set ALUOp and ALUSrc per class: R-type 10/0, I-format (Opcode[5:3]=001) 10/1, lw/sw 00/1, beq/bne 01/0.
REQ-022 From EXEC, lw/sw SHALL go to MEM, and R-type/I-format SHALL go to WB.
REQ-023 From EXEC, beq SHALL assert PCWrite with PCSrc=01 iff Zero=1, bne iff Zero=0, then go to FETCH.
REQ-024 From EXEC, j SHALL assert PCWrite with PCSrc=10, then go to FETCH.
REQ-025 From EXEC, jal SHALL assert PCWrite with PCSrc=10 and RegWrite, then go to FETCH.
REQ-026 From EXEC, jr (Opcode=0, funct=001000) SHALL assert PCWrite with PCSrc=11 and no RegWrite, then go to FETCH.
REQ-027 MEM SHALL assert mem_req with IorD=1, and mem_we=1 for sw; on ack, sw SHALL go to FETCH and lw SHALL go to WB.
REQ-028 WB SHALL assert RegWrite, with MemtoReg=1 for lw and RegDST=1 for R-type, then go to FETCH.
REQ-029 Any other opcode in EXEC SHALL set fault and go to HALT.
REQ-030 A wait in FETCH or MEM exceeding MEM_TIMEOUT cycles SHALL set fault and go to HALT.
REQ-031 HALT SHALL hold all enables low until reset.
REQ-032 retired SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, wrapping 0xFFFFFFFF to 0.
REQ-033 Latencies with immediate ack SHALL be: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3.

Reset
REQ-034 With reset=0 at an edge, the block SHALL set state=FETCH, retired=0, fault=0 and the timeout counter to 0, aborting any access in progress.
REQ-035 During reset all enables SHALL be 0, except mem_req, which SHALL rise in the first cycle after release.

Structure
REQ-036 Opcode/funct constants, state encoding, PCSrc and ALUOp codes SHALL live in the shared package cpu_pkg.
REQ-037 Instruction-class decode SHALL be one combinational sub-module, op_class_decode, instantiated once.

Verification
REQ-038 Bench SHALL check: R-type add (0x00000020) with ack every cycle -> states 0,1,2,4,0; RegWrite and RegDST high in WB; retired=1.
REQ-039 Bench SHALL check: lw (0x23) with ack delayed 3 cycles in MEM -> mem_req high 4 cycles, IorD=1; WB has MemtoReg=1; 8 cycles total.
REQ-040 Bench SHALL check: beq with Zero=1 -> PCWrite with PCSrc=01 in EXEC; bne with Zero=1 -> PCWrite low in EXEC after the FETCH pulse.
REQ-041 Bench SHALL check: jr -> PCSrc=11 and RegWrite=0 throughout; jal -> RegWrite and PCSrc=10 in the same EXEC cycle.
REQ-042 Bench SHALL check: opcode 0x3F -> fault=1 and state=5; mem_ack withheld 256 cycles in FETCH -> fault=1.
REQ-043 Bench SHALL check: reset low mid-MEM -> next state FETCH, retired=0, mem_we=0.
